// File: rtl/music_pkg.sv
// Shared MusicPlayer definitions: sequencer state encoding and the note/duration
// field layout used by the song ROM and tone generator.
package music_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF  = 3;
  localparam int NOTE_END   = 0;

  function automatic logic is_active(input logic [2:0] s);
    return s != ST_IDLE;
  endfunction
endpackage

// File: rtl/song_sequencer_tempo_tick.sv
// Beat timebase: counts enabled clocks and flags the last clock of each beat.
module tempo_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ena,
  output logic tick
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Combinational so the sequencer can act on the wrap in the same cycle.
  assign tick = ena && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (ena) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the registered song ROM, holds each note for its beat count,
// and handles play/pause/stop from the front panel.
module song_sequencer
  import music_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int ADDR_W   = 5,
  parameter int NOTE_W   = NOTE_W_DEF,
  parameter int DUR_W    = DUR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              beat,
  output logic              playing,
  output logic              done
);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic              nv_q, nv_d, beat_q, beat_d, play_q, play_d, done_q, done_d;
  logic              tick;

  tempo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state_q == ST_LOAD) || stop),
    .ena  (state_q == ST_PLAY),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    rem_d   = rem_q;
    nv_d    = nv_q;
    beat_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (!stop && !pause && play) begin
        state_d = ST_FETCH;
        addr_d  = '0;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        if (rom_note == NOTE_W'(NOTE_END)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          addr_d  = '0;
        end else begin
          state_d = ST_PLAY;
          note_d  = rom_note;
          rem_d   = rom_dur;
          nv_d    = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          beat_d = 1'b1;
          if (rem_q == '0) begin
            // Note finished: a pause landing here is dropped, the song advances.
            nv_d = 1'b0;
            if (&addr_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              addr_d  = '0;
            end else begin
              state_d = ST_FETCH;
              addr_d  = addr_q + 1'b1;
            end
          end else begin
            rem_d = rem_q - 1'b1;
            if (pause) begin
              state_d = ST_PAUSE;
              nv_d    = 1'b0;
            end
          end
        end else if (pause) begin
          state_d = ST_PAUSE;
          nv_d    = 1'b0;
        end
      end
      ST_PAUSE: if (play) begin
        state_d = ST_PLAY;
        nv_d    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Stop overrides everything, including a beat or advance in the same cycle.
    if (stop && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      rem_d   = '0;
      nv_d    = 1'b0;
      beat_d  = 1'b0;
      done_d  = 1'b0;
    end
    play_d = is_active(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      rem_q   <= '0;
      nv_q    <= 1'b0;
      beat_q  <= 1'b0;
      play_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      rem_q   <= rem_d;
      nv_q    <= nv_d;
      beat_q  <= beat_d;
      play_q  <= play_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign note_out   = note_q;
  assign note_valid = nv_q;
  assign beat       = beat_q;
  assign playing    = play_q;
  assign done       = done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: main instance ADDR_W=5, second instance ADDR_W=2
// for the address-wrap ending; both TICK_DIV=4 with registered ROM models.
module tb_song_sequencer;
  logic clk = 1'b0;
  logic rst, play, pause, stop, play2;
  logic [5:0] rom_note, rom_note2, note_out, note_out2;
  logic [2:0] rom_dur, rom_dur2;
  logic [4:0] rom_addr;
  logic [1:0] rom_addr2;
  logic note_valid, beat, playing, done;
  logic note_valid2, beat2, playing2, done2;
  logic [5:0] rn1 [32];
  logic [2:0] rd1 [32];
  logic [5:0] rn2 [4];
  logic [2:0] rd2 [4];

  int n_assert = 0, n_fail = 0;
  int nvcnt [64];
  int first_nv [64];
  int last_nv [64];
  int beats, dones, first_beat, done_idx, max_addr;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_note  <= rn1[rom_addr];
    rom_dur   <= rd1[rom_addr];
    rom_note2 <= rn2[rom_addr2];
    rom_dur2  <= rd2[rom_addr2];
  end

  song_sequencer #(.TICK_DIV(4), .ADDR_W(5), .NOTE_W(6), .DUR_W(3)) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .rom_note(rom_note), .rom_dur(rom_dur), .rom_addr(rom_addr), .note_out(note_out),
    .note_valid(note_valid), .beat(beat), .playing(playing), .done(done));

  song_sequencer #(.TICK_DIV(4), .ADDR_W(2), .NOTE_W(6), .DUR_W(3)) dut2 (
    .clk(clk), .rst(rst), .play(play2), .pause(1'b0), .stop(1'b0),
    .rom_note(rom_note2), .rom_dur(rom_dur2), .rom_addr(rom_addr2), .note_out(note_out2),
    .note_valid(note_valid2), .beat(beat2), .playing(playing2), .done(done2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples n cycles (current one first), then leaves us n cycles later.
  task automatic observe(input int n, input bit two);
    logic nv, bt, dn;
    logic [5:0] nt;
    int ad;
    for (int i = 0; i < 64; i++) begin
      nvcnt[i] = 0; first_nv[i] = -1; last_nv[i] = -1;
    end
    beats = 0; dones = 0; first_beat = -1; done_idx = -1; max_addr = 0;
    for (int i = 0; i < n; i++) begin
      nv = two ? note_valid2 : note_valid;
      nt = two ? note_out2 : note_out;
      bt = two ? beat2 : beat;
      dn = two ? done2 : done;
      ad = two ? int'(rom_addr2) : int'(rom_addr);
      if (nv) begin
        nvcnt[nt]++;
        if (first_nv[nt] < 0) first_nv[nt] = i;
        last_nv[nt] = i;
      end
      if (bt) begin
        beats++;
        if (first_beat < 0) first_beat = i;
      end
      if (dn) begin
        dones++;
        done_idx = i;
      end
      if (ad > max_addr) max_addr = ad;
      step();
    end
  endtask

  task automatic start_play();
    play = 1'b1;
    step();
    play = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; play2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rn1[i] = '0; rd1[i] = '0;
    end
    rn1[0] = 6'd5; rd1[0] = 3'd1;
    rn1[1] = 6'd7; rd1[1] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      rn2[i] = 6'(i + 1); rd2[i] = 3'd0;
    end
    step();
    step();
    chk("rst_note_valid", note_valid, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_note_out", note_out, 0);
    chk("rst_playing", playing, 0);
    chk("rst_beat", beat, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Song 5/d1, 7/d0, END
    play = 1'b1;
    step();
    play = 1'b0;
    chk("t1_fetch_playing", playing, 1);
    chk("t1_fetch_nv", note_valid, 0);
    step();
    chk("t1_load_nv", note_valid, 0);
    step();
    chk("t1_e3_nv", note_valid, 1);
    chk("t1_e3_note", note_out, 5);
    observe(20, 1'b0);
    chk("t1_note5_clks", nvcnt[5], 8);
    chk("t1_note7_clks", nvcnt[7], 4);
    chk("t1_gap", first_nv[7] - last_nv[5] - 1, 2);
    chk("t1_first_beat", first_beat, 4);
    chk("t1_beats", beats, 3);
    chk("t1_dones", dones, 1);
    chk("t1_done_idx", done_idx, 16);
    chk("t1_end_addr", rom_addr, 0);
    chk("t1_end_playing", playing, 0);

    // Pause after one clock of note 5, hold 10 clocks
    start_play();
    chk("t2_nv_start", note_valid, 1);
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("t2_paused_playing", playing, 1);
    chk("t2_paused_note", note_out, 5);
    for (int i = 0; i < 10; i++) begin
      chk("t2_paused_nv", note_valid, 0);
      if (i == 9) play = 1'b1;
      step();
    end
    play = 1'b0;
    observe(12, 1'b0);
    chk("t2_note5_rest", nvcnt[5], 7);
    chk("t2_first_beat", first_beat, 3);

    // Stop + pause on the cycle note 7 would beat and advance
    chk("t3_pre_note", note_out, 7);
    chk("t3_pre_nv", note_valid, 1);
    stop = 1'b1; pause = 1'b1;
    step();
    stop = 1'b0; pause = 1'b0;
    chk("t3_nv", note_valid, 0);
    chk("t3_addr", rom_addr, 0);
    chk("t3_done", done, 0);
    chk("t3_beat", beat, 0);
    chk("t3_playing", playing, 0);
    observe(4, 1'b0);
    chk("t3_no_done", dones, 0);
    chk("t3_stays_idle", playing, 0);

    // ADDR_W=2 song without END ends on address wrap
    play2 = 1'b1;
    step();
    play2 = 1'b0;
    step();
    step();
    observe(26, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("t4_note_clks", nvcnt[k], 4);
      chk("t4_note_start", first_nv[k], 6 * (k - 1));
    end
    chk("t4_done_idx", done_idx, 22);
    chk("t4_dones", dones, 1);
    chk("t4_end_addr", rom_addr2, 0);
    chk("t4_end_playing", playing2, 0);

    // play pulses in FETCH and PLAY are ignored
    play = 1'b1;
    step();
    step();
    play = 1'b0;
    step();
    chk("t5_nv", note_valid, 1);
    chk("t5_addr", rom_addr, 0);
    play = 1'b1;
    step();
    play = 1'b0;
    chk("t5_still_note5", note_out, 5);
    chk("t5_addr_after", rom_addr, 0);
    observe(24, 1'b0);
    chk("t5_note5_rest", nvcnt[5], 7);
    chk("t5_note7_clks", nvcnt[7], 4);
    chk("t5_max_addr", max_addr, 2);
    chk("t5_dones", dones, 1);

    // Async reset between edges during PLAY
    start_play();
    step();
    step();
    chk("t6_pre_nv", note_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_nv", note_valid, 0);
    chk("t6_rst_playing", playing, 0);
    chk("t6_rst_note", note_out, 0);
    chk("t6_rst_addr", rom_addr, 0);
    chk("t6_rst_done", done, 0);
    step();
    rst = 1'b0;
    play = 1'b1;
    step();
    play = 1'b0;
    step();
    chk("t6_e2_nv", note_valid, 0);
    step();
    chk("t6_e3_nv", note_valid, 1);
    chk("t6_e3_note", note_out, 5);
    chk("t6_e3_addr", rom_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
